// File: rtl/adder_pkg.sv
// Shared sizing for the sliced ripple-carry pipeline: default operand width,
// default stage count and the per-stage slice width.
package adder_pkg;

  localparam int ADDER_WIDTH  = 8;
  localparam int ADDER_STAGES = 2;

  // Each stage consumes an equal, contiguous slice of the operands.
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered slice of the carry pipeline: adds operand slice IDX with the incoming carry; 1 cycle.
// Backpressure: all state holds while en=0; async active-low reset clears valid, sum, carry and operands.
module adder_stage #(
  parameter int WIDTH = 8,
  parameter int SW    = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic             c_in,
  output logic             vld_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] s_q,
  output logic             c_q
);

  localparam int LSB = IDX * SW;

  logic [SW:0]      slice_sum;
  logic [WIDTH-1:0] s_nxt;

  // Lower sum slices come in finished; only this stage's slice is filled in.
  always_comb begin
    slice_sum        = {1'b0, a_in[LSB +: SW]} + {1'b0, b_in[LSB +: SW]} + {{SW{1'b0}}, c_in};
    s_nxt            = s_in;
    s_nxt[LSB +: SW] = slice_sum[SW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
    end else if (en) begin
      vld_q <= in_vld;
      a_q   <= a_in;
      b_q   <= b_in;
      s_q   <= s_nxt;
      c_q   <= slice_sum[SW];
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined a+b+ci (a-b-ci with sub when ADDER_PIPE_SUB_EN is defined); latency STAGES cycles, one set per cycle.
// Backpressure: whole pipe advances only when out_valid=0 or out_ready=1; in_ready mirrors that condition.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be >= 2 and an exact multiple of STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             ci_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + ~ci, so co=1 reads as "no borrow".
`ifdef ADDER_PIPE_SUB_EN
  assign b_eff  = sub ? ~b  : b;
  assign ci_eff = sub ? ~ci : ci;
`else
  assign b_eff  = b;
  assign ci_eff = ci;
`endif

  // Index k is the input of stage k; index STAGES is the pipe output.
  logic [STAGES:0]  vld_p;
  logic [STAGES:0]  c_p;
  logic [WIDTH-1:0] a_p [STAGES+1];
  logic [WIDTH-1:0] b_p [STAGES+1];
  logic [WIDTH-1:0] s_p [STAGES+1];

  assign vld_p[0] = in_valid;
  assign c_p[0]   = ci_eff;
  assign a_p[0]   = a;
  assign b_p[0]   = b_eff;
  assign s_p[0]   = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .IDX   (k)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (advance),
      .in_vld (vld_p[k]),
      .a_in   (a_p[k]),
      .b_in   (b_p[k]),
      .s_in   (s_p[k]),
      .c_in   (c_p[k]),
      .vld_q  (vld_p[k+1]),
      .a_q    (a_p[k+1]),
      .b_q    (b_p[k+1]),
      .s_q    (s_p[k+1]),
      .c_q    (c_p[k+1])
    );
  end

  logic a_msb;
  logic b_msb;

  assign a_msb     = a_p[STAGES][WIDTH-1];
  assign b_msb     = b_p[STAGES][WIDTH-1];
  assign out_valid = vld_p[STAGES];
  assign s         = s_p[STAGES];
  assign co        = c_p[STAGES];
  // All-zero registers after reset make this 0 as well.
  assign ovf       = (a_msb == b_msb) && (s[WIDTH-1] != a_msb);

  logic unused_operand_bits;
  assign unused_operand_bits = ^{a_p[STAGES][WIDTH-2:0], b_p[STAGES][WIDTH-2:0]};

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: 8-bit/2-stage instance plus a 16-bit/4-stage instance.
// Sub vectors are included when ADDER_PIPE_SUB_EN is defined.
module tb_adder_pipe;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, ci, out_valid, out_ready, co, ovf;
  logic [7:0] a, b, s;
  logic        in_valid16, in_ready16, ci16, out_valid16, out_ready16, co16, ovf16;
  logic [15:0] a16, b16, s16;
`ifdef ADDER_PIPE_SUB_EN
  logic sub, sub16;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
`ifdef ADDER_PIPE_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf)
  );

  adder_pipe #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .ci        (ci16),
`ifdef ADDER_PIPE_SUB_EN
    .sub       (sub16),
`endif
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .s         (s16),
    .co        (co16),
    .ovf       (ovf16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {ovf, co, s} for a plain add.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    v = (x[7] == y[7]) && (t[7] != x[7]);
    return {v, t[8], t[7:0]};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    a = v.a; b = v.b; ci = v.ci; in_valid = 1'b1;
`ifdef ADDER_PIPE_SUB_EN
    sub = v.sub;
`endif
    #1;
    chk($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 8) begin
      tick(); #1; lat++;
    end
    chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'd2);
    chk($sformatf("vec%0d_s", idx), 32'(s), 32'(v.s));
    chk($sformatf("vec%0d_co", idx), 32'(co), 32'(v.co));
    chk($sformatf("vec%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
    tick();
  endtask

  task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic c,
                       input logic [15:0] es, input logic eco, input logic eovf, input int idx);
    int lat;
    a16 = x; b16 = y; ci16 = c; in_valid16 = 1'b1;
    #1;
    chk($sformatf("w16_%0d_in_ready", idx), 32'(in_ready16), 32'd1);
    tick();
    in_valid16 = 1'b0;
    lat = 1;
    #1;
    while (!out_valid16 && lat < 12) begin
      tick(); #1; lat++;
    end
    chk($sformatf("w16_%0d_latency", idx), 32'(lat), 32'd4);
    chk($sformatf("w16_%0d_s", idx), 32'(s16), 32'(es));
    chk($sformatf("w16_%0d_co", idx), 32'(co16), 32'(eco));
    chk($sformatf("w16_%0d_ovf", idx), 32'(ovf16), 32'(eovf));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t           vecs[$];
    logic [7:0]     sa[14], sb[14];
    logic           sc[14];
    logic [9:0]     exp_q[$];
    logic [9:0]     frozen;
    logic [9:0]     e;
    int             n_sent, n_got;
    logic [4:0]     bub_pat;

    // a, b, ci, sub, s, co, ovf
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
    vecs.push_back('{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1});
`ifdef ADDER_PIPE_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h10, 8'h03, 1'b0, 1'b1, 8'h0D, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h09, 8'h04, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0});
    sub = 1'b0; sub16 = 1'b0;
`endif

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; ci16 = 1'b0;
    tick(); tick(); #1;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Stream with a 3-cycle stall after the first 10 results.
    for (int i = 0; i < 14; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      sc[i] = 1'($urandom);
    end
    n_sent = 0; n_got = 0; frozen = '0;
    for (int cyc = 0; cyc < 60 && n_got < 14; cyc++) begin
      out_ready = !(cyc >= 12 && cyc < 15);
      in_valid  = (n_sent < 14);
      if (n_sent < 14) begin
        a = sa[n_sent]; b = sb[n_sent]; ci = sc[n_sent];
      end
      #1;
      if (cyc >= 12 && cyc < 15) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        if (cyc == 12) frozen = {ovf, co, s};
        else chk("stall_frozen", 32'({ovf, co, s}), 32'(frozen));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_spurious", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream_res%0d", n_got), 32'({ovf, co, s}), 32'(e));
          if (n_got < 10) chk($sformatf("stream_cycle%0d", n_got), 32'(cyc), 32'(n_got + 2));
          n_got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, ci));
        n_sent++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", 32'(n_got), 32'd14);
    #1;
    chk("stream_drained", 32'(out_valid), 32'd0);
    tick();

    // Bubble between two sets must show up as a gap in out_valid.
    bub_pat = 5'b00000;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = (cyc == 0 || cyc == 2);
      a = 8'h01; b = 8'h02; ci = 1'b0;
      #1;
      bub_pat[cyc] = out_valid;
      tick();
    end
    in_valid = 1'b0;
    chk("bubble_pattern", 32'(bub_pat), 32'b10100);

    // Reset with two sets in flight.
    a = 8'h11; b = 8'h22; ci = 1'b0; in_valid = 1'b1;
    tick();
    a = 8'h33; b = 8'h44;
    tick();
    in_valid = 1'b0;
    #1;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_co", 32'(co), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk($sformatf("no_stale%0d", i), 32'(out_valid), 32'd0);
    end
    tick();
    run_vec('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0}, 99);

    // Wide, deeper pipeline.
    run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run16(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1);
    run16(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 2);
    run16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
